load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store initiator between the RISC-V core's memory stage and the word-organised data memory (byte write enables, synchronous 1-cycle read). It takes one LB/LH/LW/LBU/LHU/SB/SH/SW request from the core and computes byte lanes. Accesses that stay within one word use a single memory access. Accesses that cross a word boundary are split into two word accesses. Load data is sign- or zero-extended before it is returned with a one-cycle done pulse.

## Interface
- DM_ADDRESS, 9, byte-address width of data memory
- DATA_W, 32, data width (fixed at 32; lane logic assumes 4 bytes)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- req  in  1  core request; sampled only in IDLE
- MemRead  in  1  load request (from control unit)
- MemWrite  in  1  store request (from control unit)
- Funct3  in  3  instruction bits 14:12
- addr  in  DM_ADDRESS  byte address (ALU result LSBs)
- wd  in  DATA_W  store data (rs2)
- busy  out  1  high whenever state != IDLE; core stalls
- done  out  1  one-cycle pulse: access complete
- err  out  1  qualifies done: illegal request, no memory access
- rd  out  DATA_W  load result, valid while done=1, held until next done
- mem_addr  out  DM_ADDRESS  word-aligned byte address, bits [1:0]=0
- mem_wd  out  DATA_W  lane-aligned write data
- mem_wr  out  4  byte write enables; bit i selects bits 8i+7:8i
- mem_rd_en  out  1  read strobe
- mem_rdata  in  DATA_W  memory data, valid the cycle after mem_rd_en

## Operation
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: 000 SB, 001 SH, 010 SW.
- Illegal request: any other Funct3, MemRead and MemWrite both high, or both low.
- Offset o = addr[1:0]; size s = 1/2/4.
- A request crosses a word boundary when o+s > 4.
- Byte mask: 8-bit window with bits o..o+s-1 set. Bits [3:0] are the word0 mask; bits [7:4] are the word1 mask.
- Store data: 64-bit {32'b0, wd} shifted left by 8*o. Low half goes to word0 mem_wd, high half to word1 mem_wd.
- Load data: {word1, word0} shifted right by 8*o, truncated to s bytes. LB/LH sign-extend; LBU/LHU/LW zero-extend. word1 = 0 when the request does not cross.
- Word0 address = {addr[DM_ADDRESS-1:2], 2'b00}.
- Word1 address = word0 + 4, modulo 2^DM_ADDRESS. 0x1FC wraps to 0x000.
- States and transitions:
  - IDLE: on req, latch addr, wd, Funct3 and op. Legal request -> ISSUE0; illegal request -> ERR. Otherwise stay.
  - ISSUE0: drive word0 (mem_wr = word0 mask for a store; mem_rd_en for a load). Crossing -> ISSUE1; else -> WAIT.
  - ISSUE1: drive word1 the same way. Capture mem_rdata into the word0 buffer. -> WAIT.
  - WAIT: no memory drive. Capture mem_rdata into the last-word buffer, register assembled rd, set done. -> IDLE.
  - ERR: set done and err; rd unchanged; no memory drive. -> IDLE.
- The memory interface is idle (mem_wr=0, mem_rd_en=0) in IDLE, WAIT and ERR.
- Memory outputs are driven combinationally from state plus latched registers, never from live core inputs.
- req is ignored while busy. The core holds its inputs stable until done.

## Timing
- Reset values: state IDLE; busy, done, err, mem_wr, mem_rd_en = 0; rd, mem_addr, mem_wd = 0.
- Cycle numbering: request accepted at edge 0.
- Single-word access: ISSUE0 in cycle 1, WAIT in cycle 2, done in cycle 3.
- Split access: ISSUE0, ISSUE1, WAIT in cycles 1-3, done in cycle 4.
- Illegal request: ERR in cycle 1, done=err=1 in cycle 2.
- done is high during the IDLE cycle (busy=0). A new req in that cycle is accepted: back-to-back, no bubble.
- Store writes commit on the clock edge that ends the issue cycle.
- Reset mid-operation forces IDLE immediately; outputs return to reset values. A word already committed stays written, e.g. the first half of a split store. No done is produced.

## Test plan
- LW 0x40 after memory word 0x40 = 0xDEADBEEF -> exactly one mem_rd_en, done in cycle 3, rd = 0xDEADBEEF, err = 0.
- Word 0x40 = 0x80112233; LB 0x43 -> rd = 0xFFFFFF80; LBU 0x43 -> rd = 0x00000080; LH 0x42 -> rd = 0xFFFF8011.
- SH 0x41 with wd = 0x0000ABCD -> mem_addr = 0x40, mem_wr = 0110, mem_wd = 0x00ABCD00; then LHU 0x41 -> rd = 0x0000ABCD.
- SW 0x0E with wd = 0x11223344 -> cycle 1: mem_addr = 0x0C, mem_wr = 1100, mem_wd = 0x33440000; cycle 2: mem_addr = 0x10, mem_wr = 0011, mem_wd = 0x00001122; done in cycle 4; then LW 0x0E -> rd = 0x11223344.
- Wrap: byte 0x1FF = 0x80, byte 0x000 = 0x7F; LH 0x1FF -> second access at mem_addr = 0x000, rd = 0x00007F80; LH with bytes 0xFF/0x80 -> rd = 0xFFFF80FF.
- Funct3 = 011 with MemRead -> done = err = 1 in cycle 2, no mem_rd_en/mem_wr, rd unchanged.
- reset asserted during ISSUE1 of the split SW above -> outputs 0 at once, word 0x0C modified, word 0x10 unmodified, no done.

Source files
------------

// File: rtl/load_store_unit.sv
// Multi-cycle load/store initiator between the core memory stage and a word-organised
// data memory; splits word-crossing accesses and sign/zero-extends load results.
module load_store_unit #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wd,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_W-1:0]     rd,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wd,
    output logic [3:0]            mem_wr,
    output logic                  mem_rd_en,
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE0 = 3'd1,
        S_ISSUE1 = 3'd2,
        S_WAIT   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [DM_ADDRESS-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]       wd_q, wd_d;
    logic [2:0]              f3_q, f3_d;
    logic                    store_q, store_d;
    logic [DATA_W-1:0]       buf0_q, buf0_d;
    logic [DATA_W-1:0]       rd_q, rd_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic [1:0]              offset_s;
    logic [7:0]              base_mask_s;
    logic [7:0]              mask_s;
    logic                    cross_s;
    logic [63:0]             store_wide_s;
    logic [63:0]             load_wide_s;
    logic [DATA_W-1:0]       word0_s;
    logic [DATA_W-1:0]       word1_s;
    logic [DATA_W-1:0]       load_result_s;
    logic [DM_ADDRESS-1:0]   word0_addr_s;
    logic [DM_ADDRESS-1:0]   word1_addr_s;
    logic                    unused_s;

    function automatic logic legal_req(input logic rd_i, input logic wr_i, input logic [2:0] f3_i);
        logic ok;
        ok = 1'b0;
        if (rd_i && !wr_i) begin
            case (f3_i)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
                default:                                ok = 1'b0;
            endcase
        end else if (wr_i && !rd_i) begin
            case (f3_i)
                3'b000, 3'b001, 3'b010: ok = 1'b1;
                default:                ok = 1'b0;
            endcase
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // Lane window, word addresses and aligned store/load data from the latched request
    always_comb begin
        offset_s = addr_q[1:0];
        case (f3_q[1:0])
            2'b00:   base_mask_s = 8'h01;
            2'b01:   base_mask_s = 8'h03;
            default: base_mask_s = 8'h0F;
        endcase
        mask_s       = base_mask_s << offset_s;
        cross_s      = |mask_s[7:4];
        store_wide_s = {32'h0000_0000, wd_q} << {offset_s, 3'b000};
        word0_addr_s = {addr_q[DM_ADDRESS-1:2], 2'b00};
        // Upper word index wraps naturally at the top of the memory
        word1_addr_s = {addr_q[DM_ADDRESS-1:2] + {{(DM_ADDRESS-3){1'b0}}, 1'b1}, 2'b00};
        if (cross_s) begin
            word0_s = buf0_q;
            word1_s = mem_rdata;
        end else begin
            word0_s = mem_rdata;
            word1_s = 32'h0000_0000;
        end
        load_wide_s = {word1_s, word0_s} >> {offset_s, 3'b000};
        case (f3_q)
            3'b000:  load_result_s = {{24{load_wide_s[7]}}, load_wide_s[7:0]};
            3'b001:  load_result_s = {{16{load_wide_s[15]}}, load_wide_s[15:0]};
            3'b100:  load_result_s = {24'h00_0000, load_wide_s[7:0]};
            3'b101:  load_result_s = {16'h0000, load_wide_s[15:0]};
            default: load_result_s = load_wide_s[31:0];
        endcase
    end

    assign unused_s = ^load_wide_s[63:32];

    // Next-state, request capture and memory-side drive
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wd_d      = wd_q;
        f3_d      = f3_q;
        store_d   = store_q;
        buf0_d    = buf0_q;
        rd_d      = rd_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        mem_addr  = {DM_ADDRESS{1'b0}};
        mem_wd    = 32'h0000_0000;
        mem_wr    = 4'b0000;
        mem_rd_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    wd_d    = wd;
                    f3_d    = Funct3;
                    store_d = MemWrite;
                    state_d = legal_req(MemRead, MemWrite, Funct3) ? S_ISSUE0 : S_ERR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE0: begin
                mem_addr = word0_addr_s;
                if (store_q) begin
                    mem_wd = store_wide_s[31:0];
                    mem_wr = mask_s[3:0];
                end else begin
                    mem_rd_en = 1'b1;
                end
                state_d = cross_s ? S_ISSUE1 : S_WAIT;
            end
            S_ISSUE1: begin
                mem_addr = word1_addr_s;
                if (store_q) begin
                    mem_wd = store_wide_s[63:32];
                    mem_wr = mask_s[7:4];
                end else begin
                    mem_rd_en = 1'b1;
                end
                buf0_d  = mem_rdata;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!store_q) begin
                    rd_d = load_result_s;
                end else begin
                    rd_d = rd_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                done_d  = 1'b1;
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= {DM_ADDRESS{1'b0}};
            wd_q    <= 32'h0000_0000;
            f3_q    <= 3'b000;
            store_q <= 1'b0;
            buf0_q  <= 32'h0000_0000;
            rd_q    <= 32'h0000_0000;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            f3_q    <= f3_d;
            store_q <= store_d;
            buf0_q  <= buf0_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign err  = err_q;
    assign rd   = rd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a byte-addressed memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [8:0]  addr;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rd;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wd;
    logic [3:0]  mem_wr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;

    logic [7:0]  mem [0:511];

    int vectors = 0;
    int miscompares = 0;
    int lat;
    int rd_en_cnt;
    int wr_cnt;
    logic [8:0]  log_addr [0:7];
    logic [3:0]  log_wr   [0:7];
    logic [31:0] log_wd   [0:7];

    load_store_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .req(req), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .addr(addr), .wd(wd), .busy(busy), .done(done), .err(err),
        .rd(rd), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_wr(mem_wr),
        .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Word-organised memory: byte-enabled writes, one-cycle registered read
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_wr[b]) mem[{mem_addr[8:2], 2'b00} + 9'(b)] <= mem_wd[8*b +: 8];
        end
        if (mem_rd_en) begin
            mem_rdata <= {mem[{mem_addr[8:2], 2'b11}], mem[{mem_addr[8:2], 2'b10}],
                          mem[{mem_addr[8:2], 2'b01}], mem[{mem_addr[8:2], 2'b00}]};
        end
    end

    task automatic set_word(input logic [8:0] a, input logic [31:0] w);
        for (int b = 0; b < 4; b++) mem[a + 9'(b)] = w[8*b +: 8];
    endtask

    function automatic logic [31:0] get_word(input logic [8:0] a);
        return {mem[a + 9'd3], mem[a + 9'd2], mem[a + 9'd1], mem[a]};
    endfunction

    // Issue one request in the current cycle and follow it until done (bounded)
    task automatic do_req(input logic mr, input logic mw, input logic [2:0] f3,
                          input logic [8:0] a, input logic [31:0] d);
        req = 1'b1; MemRead = mr; MemWrite = mw; Funct3 = f3; addr = a; wd = d;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 0; rd_en_cnt = 0; wr_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k < 8) begin
                log_addr[k] = mem_addr; log_wr[k] = mem_wr; log_wd[k] = mem_wd;
            end
            if (mem_rd_en) rd_en_cnt++;
            if (mem_wr != 4'b0000) wr_cnt++;
            if (done) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        vectors++; if ({busy, done, err, mem_wr, mem_rd_en} !== 8'h00) begin miscompares++; $display("FAIL reset_ctrl: got %b required 00000000", {busy, done, err, mem_wr, mem_rd_en}); end
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL reset_rd: got %h required 00000000", rd); end
        vectors++; if ({mem_addr, mem_wd} !== 41'h0) begin miscompares++; $display("FAIL reset_mem: got addr %h wd %h required 0", mem_addr, mem_wd); end
    endtask

    task automatic test_lw();
        set_word(9'h040, 32'hDEADBEEF);
        do_req(1'b1, 1'b0, 3'b010, 9'h040, 32'h0);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL lw_latency: got %0d required 3", lat); end
        vectors++; if (rd_en_cnt !== 1) begin miscompares++; $display("FAIL lw_rd_en_count: got %0d required 1", rd_en_cnt); end
        vectors++; if (log_addr[1] !== 9'h040) begin miscompares++; $display("FAIL lw_addr: got %h required 040", log_addr[1]); end
        vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lw_rd: got %h required deadbeef", rd); end
        vectors++; if (err !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL lw_err_busy: got %b%b required 00", err, busy); end
    endtask

    task automatic test_back_to_back();
        set_word(9'h040, 32'h80112233);
        do_req(1'b1, 1'b0, 3'b000, 9'h043, 32'h0);
        vectors++; if (rd !== 32'hFFFFFF80) begin miscompares++; $display("FAIL lb_rd: got %h required ffffff80", rd); end
        do_req(1'b1, 1'b0, 3'b100, 9'h043, 32'h0);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL b2b_latency: got %0d required 3", lat); end
        vectors++; if (rd !== 32'h00000080) begin miscompares++; $display("FAIL lbu_rd: got %h required 00000080", rd); end
        do_req(1'b1, 1'b0, 3'b001, 9'h042, 32'h0);
        vectors++; if (rd !== 32'hFFFF8011) begin miscompares++; $display("FAIL lh_rd: got %h required ffff8011", rd); end
    endtask

    task automatic test_sh();
        do_req(1'b0, 1'b1, 3'b001, 9'h041, 32'h0000ABCD);
        vectors++; if (log_addr[1] !== 9'h040) begin miscompares++; $display("FAIL sh_addr: got %h required 040", log_addr[1]); end
        vectors++; if (log_wr[1] !== 4'b0110) begin miscompares++; $display("FAIL sh_wr: got %b required 0110", log_wr[1]); end
        vectors++; if (log_wd[1] !== 32'h00ABCD00) begin miscompares++; $display("FAIL sh_wd: got %h required 00abcd00", log_wd[1]); end
        vectors++; if (lat !== 3 || wr_cnt !== 1) begin miscompares++; $display("FAIL sh_timing: got lat %0d writes %0d required 3 1", lat, wr_cnt); end
        do_req(1'b1, 1'b0, 3'b101, 9'h041, 32'h0);
        vectors++; if (rd !== 32'h0000ABCD) begin miscompares++; $display("FAIL lhu_rd: got %h required 0000abcd", rd); end
    endtask

    task automatic test_split_store();
        do_req(1'b0, 1'b1, 3'b010, 9'h00E, 32'h11223344);
        vectors++; if ({log_addr[1], log_wr[1], log_wd[1]} !== {9'h00C, 4'b1100, 32'h33440000}) begin miscompares++; $display("FAIL sw0: got %h %b %h required 00c 1100 33440000", log_addr[1], log_wr[1], log_wd[1]); end
        vectors++; if ({log_addr[2], log_wr[2], log_wd[2]} !== {9'h010, 4'b0011, 32'h00001122}) begin miscompares++; $display("FAIL sw1: got %h %b %h required 010 0011 00001122", log_addr[2], log_wr[2], log_wd[2]); end
        vectors++; if (lat !== 4) begin miscompares++; $display("FAIL sw_latency: got %0d required 4", lat); end
        do_req(1'b1, 1'b0, 3'b010, 9'h00E, 32'h0);
        vectors++; if (rd !== 32'h11223344 || lat !== 4 || rd_en_cnt !== 2) begin miscompares++; $display("FAIL lw_split: got %h lat %0d reads %0d required 11223344 4 2", rd, lat, rd_en_cnt); end
    endtask

    task automatic test_wrap();
        mem[9'h1FF] = 8'h80; mem[9'h000] = 8'h7F;
        do_req(1'b1, 1'b0, 3'b001, 9'h1FF, 32'h0);
        vectors++; if (log_addr[1] !== 9'h1FC || log_addr[2] !== 9'h000) begin miscompares++; $display("FAIL wrap_addr: got %h %h required 1fc 000", log_addr[1], log_addr[2]); end
        vectors++; if (rd !== 32'h00007F80) begin miscompares++; $display("FAIL wrap_rd_pos: got %h required 00007f80", rd); end
        mem[9'h1FF] = 8'hFF; mem[9'h000] = 8'h80;
        do_req(1'b1, 1'b0, 3'b001, 9'h1FF, 32'h0);
        vectors++; if (rd !== 32'hFFFF80FF) begin miscompares++; $display("FAIL wrap_rd_neg: got %h required ffff80ff", rd); end
    endtask

    task automatic test_illegal();
        do_req(1'b1, 1'b0, 3'b011, 9'h040, 32'h0);
        vectors++; if (lat !== 2 || err !== 1'b1) begin miscompares++; $display("FAIL illegal_f3: got lat %0d err %b required 2 1", lat, err); end
        vectors++; if (rd_en_cnt !== 0 || wr_cnt !== 0) begin miscompares++; $display("FAIL illegal_mem: got reads %0d writes %0d required 0 0", rd_en_cnt, wr_cnt); end
        vectors++; if (rd !== 32'hFFFF80FF) begin miscompares++; $display("FAIL illegal_rd_held: got %h required ffff80ff", rd); end
        @(posedge clk); #1;
        vectors++; if (done !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL illegal_pulse: got done %b err %b required 0 0", done, err); end
        do_req(1'b1, 1'b1, 3'b010, 9'h040, 32'h0);
        vectors++; if (lat !== 2 || err !== 1'b1 || wr_cnt !== 0 || rd_en_cnt !== 0) begin miscompares++; $display("FAIL illegal_both: got lat %0d err %b required 2 1", lat, err); end
        do_req(1'b0, 1'b0, 3'b010, 9'h040, 32'h0);
        vectors++; if (lat !== 2 || err !== 1'b1) begin miscompares++; $display("FAIL illegal_none: got lat %0d err %b required 2 1", lat, err); end
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        set_word(9'h00C, 32'hAAAAAAAA);
        set_word(9'h010, 32'hAAAAAAAA);
        req = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Funct3 = 3'b010; addr = 9'h00E; wd = 32'h11223344;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        vectors++; if ({busy, done, err, mem_wr, mem_rd_en} !== 8'h00 || {mem_addr, mem_wd} !== 41'h0) begin miscompares++; $display("FAIL midreset_outputs: got busy %b wr %b addr %h wd %h required 0", busy, mem_wr, mem_addr, mem_wd); end
        @(posedge clk); #1;
        reset = 1'b0; MemWrite = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (done) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        vectors++; if (saw_done !== 1'b0) begin miscompares++; $display("FAIL midreset_no_done: got done seen required none"); end
        vectors++; if (get_word(9'h00C) !== 32'h3344AAAA) begin miscompares++; $display("FAIL midreset_word0: got %h required 3344aaaa", get_word(9'h00C)); end
        vectors++; if (get_word(9'h010) !== 32'hAAAAAAAA) begin miscompares++; $display("FAIL midreset_word1: got %h required aaaaaaaa", get_word(9'h010)); end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem_rdata = 32'h0;
        reset = 1'b1; req = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Funct3 = 3'b000; addr = 9'h000; wd = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        test_lw();
        test_back_to_back();
        test_sh();
        test_split_store();
        test_wrap();
        test_illegal();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
